// File: rtl/dm_sram_resp.sv
// dm_sram_resp: data-memory responder for the MEM stage.
// Single-port synchronous SRAM with per-byte write enables and a one-cycle
// registered read. After reset an internal sweep zeroes every word before
// dm_ready rises (when CLEAR_ON_RESET=1).
// Optional build macro: DM_RANGE_CHK_EN enables the BASE_ADDR-relative
// out-of-range check and the dm_err response flag.
module dm_sram_resp #(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RDY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    ready_q, ready_d;
    logic                    zero_q, zero_d;

    // Access decode: word index and whether the access may touch memory.
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic                    acc_in_range;

`ifdef DM_RANGE_CHK_EN
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

    logic [31:0] offs;
    logic        unused_addr_bits;

    // Offset from the window base; one extra bit so a full 4 GiB span compares cleanly.
    assign offs             = dm_addr - BASE_ADDR;
    assign acc_in_range     = ({1'b0, offs} < SPAN_BYTES);
    assign acc_idx          = offs[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^offs;
`else
    logic unused_addr_bits;

    // Without the range check the index comes straight from the byte address
    // and aliases modulo DEPTH words.
    assign acc_in_range     = 1'b1;
    assign acc_idx          = dm_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{dm_addr, BASE_ADDR};
`endif

    // Next-state logic for the clear sweep and the response flags.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                state_d = ST_RDY;
            end
        end
        ready_d = (state_d == ST_RDY);
        // Response is forced to zero while clearing and for rejected accesses.
        zero_d  = (state_q != ST_RDY) || !acc_in_range;
    end

    // State register; reset restarts the sweep (or goes straight to RDY).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLR : ST_RDY;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            zero_q    <= zero_d;
        end
    end

`ifdef DM_RANGE_CHK_EN
    logic err_q;

    // Out-of-range flag, aligned with the read data it accompanies.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_RDY) && !acc_in_range;
        end
    end

    assign dm_err = err_q;
`else
    assign dm_err = 1'b0;
`endif

    // Shared single port: the clear sweep owns the address during CLR.
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_we;
    logic [31:0]           raw_rdata;

    assign mem_addr  = (state_q == ST_CLR) ? clr_cnt_q : acc_idx;
    assign mem_wdata = (state_q == ST_CLR) ? 32'h0 : dm_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // Writes are blocked during reset so contents survive when clearing is off.
            assign mem_we[gi] = !reset &&
                                ((state_q == ST_CLR) ||
                                 (dm_wen[gi] && acc_in_range));

            // One byte lane of the RAM: read-first, registered read port.
            always_ff @(posedge clk) begin
                if (mem_we[gi]) begin
                    mem[mem_addr] <= mem_wdata[8*gi +: 8];
                end
                rd_q <= mem[mem_addr];
            end

            assign raw_rdata[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign dm_rdata = zero_q ? 32'h0 : raw_rdata;
    assign dm_ready = ready_q;

endmodule

// File: tb/tb_dm_sram_resp.sv
// Testbench for dm_sram_resp: two instances (clear-on-reset on and off)
// driven with directed and random traffic, checked every cycle against a
// word-array reference model, plus literal expectations from the test plan.
module tb_dm_sram_resp;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DM_RANGE_CHK_EN
    localparam logic [31:0] AB = BASE;
`else
    localparam logic [31:0] AB = 32'h0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [31:0] addr, wdata;
    logic [3:0]  wen;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, err0, err1;

    dm_sram_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .dm_addr(addr), .dm_wen(wen), .dm_wdata(wdata),
        .dm_rdata(rd0), .dm_ready(rdy0), .dm_err(err0)
    );

    dm_sram_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .reset(rst1), .dm_addr(addr), .dm_wen(wen), .dm_wdata(wdata),
        .dm_rdata(rd1), .dm_ready(rdy1), .dm_err(err1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: memory image per instance, known-word flags,
    // remaining clear cycles, and expected outputs after the latest edge.
    logic [31:0] mm  [2][DEPTH];
    bit          kn  [2][DEPTH];
    int          clr_left [2];
    bit          clr_cfg  [2];
    logic [31:0] exp_rd   [2];
    bit          exp_rk   [2];
    bit          exp_rdy  [2];
    bit          exp_err  [2];

    function automatic void model_edge(int k, bit r, logic [31:0] a, logic [3:0] w, logic [31:0] d);
        logic [31:0] off;
        int          idx;
        bit          inr;
        if (r) begin
            exp_rd[k] = 32'h0; exp_rk[k] = 1'b1; exp_err[k] = 1'b0; exp_rdy[k] = 1'b0;
            if (clr_cfg[k]) begin
                clr_left[k] = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    mm[k][i] = 32'h0;
                    kn[k][i] = 1'b1;
                end
            end else begin
                clr_left[k] = 0;
            end
        end else if (clr_left[k] > 0) begin
            clr_left[k]--;
            exp_rd[k] = 32'h0; exp_rk[k] = 1'b1; exp_err[k] = 1'b0;
            exp_rdy[k] = (clr_left[k] == 0);
        end else begin
            exp_rdy[k] = 1'b1;
`ifdef DM_RANGE_CHK_EN
            off = a - BASE;
            inr = (off < 32'(DEPTH * 4));
`else
            off = a;
            inr = 1'b1;
`endif
            idx = int'((off >> 2) % DEPTH);
            if (!inr) begin
                exp_rd[k] = 32'h0; exp_rk[k] = 1'b1; exp_err[k] = 1'b1;
            end else begin
                exp_rd[k] = mm[k][idx]; exp_rk[k] = kn[k][idx]; exp_err[k] = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    if (w[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
                end
                if (w == 4'hF) kn[k][idx] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare both instances.
    task automatic step(input bit r0, input bit r1, input logic [31:0] a,
                        input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        rst0 = r0; rst1 = r1; addr = a; wen = w; wdata = d;
        model_edge(0, r0, a, w, d);
        model_edge(1, r1, a, w, d);
        @(posedge clk);
        #1;
        chk("rdy0", 32'(rdy0), 32'(exp_rdy[0]));
        chk("rdy1", 32'(rdy1), 32'(exp_rdy[1]));
        chk("err0", 32'(err0), 32'(exp_err[0]));
        chk("err1", 32'(err1), 32'(exp_err[1]));
        if (exp_rk[0]) chk("rdata0", rd0, exp_rd[0]);
        if (exp_rk[1]) chk("rdata1", rd1, exp_rd[1]);
        $display("r=%0d%0d addr=%h wen=%b wd=%h | rd0=%h rdy0=%0d err0=%0d | rd1=%h rdy1=%0d err1=%0d",
                 r0, r1, a, w, d, rd0, rdy0, err0, rd1, rdy1, err1);
    endtask

    initial begin
        clr_cfg[0] = 1'b1;
        clr_cfg[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                mm[k][i] = 32'h0;
                kn[k][i] = 1'b0;
            end
        end
        rst0 = 1'b1; rst1 = 1'b1; addr = 32'h0; wen = 4'h0; wdata = 32'h0;

        // Power-up reset, then fill dut1 while dut0 clears.
        step(1, 1, AB, 4'h0, 32'h0);
        chk("lit_rst_rdata0", rd0, 32'h0);
        chk("lit_rst_rdy0", 32'(rdy0), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AB + 32'(i * 4), 4'hF, 32'hA000_0000 | 32'(i + 1));
            chk("lit_first_clr_rdy0", 32'(rdy0), (i == DEPTH - 1) ? 32'h1 : 32'h0);
            if (i == 0) chk("lit_noclr_rdy1", 32'(rdy1), 32'h1);
        end

        // Pre-fill dut0 with nonzero data.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AB + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i));
        end

        // Reset pulse: 16 cycles not ready, ready on the 17th, memory all zero.
        step(1, 0, AB, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AB + 32'(i * 4), 4'h0, 32'h0);
            chk("lit_clr_rdy0", 32'(rdy0), (i == DEPTH - 1) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AB + 32'(i * 4), 4'h0, 32'h0);
            chk("lit_cleared_word", rd0, 32'h0);
        end

        // Full-word write and readback.
        step(0, 0, AB + 32'h8, 4'hF, 32'hDEAD_BEEF);
        step(0, 0, AB + 32'h8, 4'h0, 32'h0);
        chk("lit_word_rd", rd0, 32'hDEAD_BEEF);

        // Byte and halfword writes.
        step(0, 0, AB + 32'hA, 4'b0100, 32'h00AA_0000);
        step(0, 0, AB + 32'h8, 4'h0, 32'h0);
        chk("lit_byte_rd", rd0, 32'hDEAA_BEEF);
        step(0, 0, AB + 32'h8, 4'b0011, 32'h0000_1234);
        step(0, 0, AB + 32'h8, 4'h0, 32'h0);
        chk("lit_half_rd", rd0, 32'hDEAA_1234);

        // Read-first on a same-cycle write.
        step(0, 0, AB + 32'h8, 4'hF, 32'h1111_1111);
        chk("lit_read_first", rd0, 32'hDEAA_1234);
        step(0, 0, AB + 32'h8, 4'h0, 32'h0);
        chk("lit_after_write", rd0, 32'h1111_1111);

        // Reset again mid-clear (counter at 5): the clear restarts in full.
        step(1, 0, AB, 4'h0, 32'h0);
        repeat (5) step(0, 0, AB, 4'h0, 32'h0);
        step(1, 0, AB, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AB, 4'h0, 32'h0);
            chk("lit_restart_rdy0", 32'(rdy0), (i == DEPTH - 1) ? 32'h1 : 32'h0);
        end

        // Contents persist across reset when clearing is disabled.
        step(0, 0, AB + 32'h8, 4'hF, 32'h600D_CAFE);
        step(0, 1, AB, 4'h0, 32'h0);
        chk("lit_persist_rst_rdata1", rd1, 32'h0);
        chk("lit_persist_rst_rdy1", 32'(rdy1), 32'h0);
        step(0, 0, AB + 32'h8, 4'h0, 32'h0);
        chk("lit_persist_rd1", rd1, 32'h600D_CAFE);
        chk("lit_persist_rdy1", 32'(rdy1), 32'h1);

`ifdef DM_RANGE_CHK_EN
        // Out-of-range write is dropped and flagged; in-range clears the flag.
        step(0, 0, 32'h0000_1000, 4'hF, 32'h1234_5678);
        step(0, 0, 32'h0000_1040, 4'hF, 32'hFFFF_FFFF);
        chk("lit_oor_rdata", rd0, 32'h0);
        chk("lit_oor_err", 32'(err0), 32'h1);
        step(0, 0, 32'h0000_1000, 4'h0, 32'h0);
        chk("lit_oor_unchanged", rd0, 32'h1234_5678);
        chk("lit_inr_err0", 32'(err0), 32'h0);
        step(0, 0, 32'h0000_1008, 4'h0, 32'h0);
        chk("lit_inr_err", 32'(err0), 32'h0);
`else
        // Address aliasing modulo DEPTH words.
        step(0, 0, 32'h0000_0048, 4'hF, 32'h55AA_55AA);
        step(0, 0, 32'h0000_0008, 4'h0, 32'h0);
        chk("lit_wrap_rd", rd0, 32'h55AA_55AA);
        chk("lit_wrap_err", 32'(err0), 32'h0);
`endif

        // Random traffic with occasional resets on either instance.
        for (int n = 0; n < 400; n++) begin
            bit          r0, r1;
            logic [31:0] a;
            r0 = ($urandom_range(0, 59) == 0);
            r1 = ($urandom_range(0, 59) == 0);
            a  = AB + 32'($urandom_range(0, 175)) - 32'h10;
            step(r0, r1, a, 4'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_sram_resp.md
Name: dm_sram_resp

Overview:
- Data-memory responder for the MEM stage's dm_addr / dm_wen / dm_wdata / dm_rdata interface.
- Single-port synchronous SRAM model with per-byte write enables and 1-cycle registered read data, matching MEM's two-cycle load timing.
- After reset, a clear FSM zeroes every word before the memory reports ready.
- Sits beside the CPU top as the data RAM; the instruction side is untouched.

Parameters:
ADDR_WIDTH, 10, word-index bits; DEPTH = 2**ADDR_WIDTH words.
BASE_ADDR, 32'h0000_0000, byte address of word 0; used only by the optional range check.
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip clearing, contents persist across reset.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
dm_addr  input  32  byte address from MEM; word index = dm_addr[ADDR_WIDTH+1:2]; bits [1:0] ignored.
dm_wen  input  4  byte-lane write enables; bit i writes dm_wdata[8i+7:8i].
dm_wdata  input  32  lane-aligned store data.
dm_rdata  output  32  registered read data for the address presented in the previous cycle.
dm_ready  output  1  high when the memory accepts accesses (state RDY).
dm_err  output  1  registered out-of-range flag; present only with DM_RANGE_CHK_EN, otherwise tied 0.

Behaviour:
- Reset (reset=1 at posedge):
  - Outputs: dm_rdata=0, dm_ready=0, dm_err=0.
  - State: clr_cnt=0; state=CLR if CLEAR_ON_RESET=1, else state=RDY.
  - With CLEAR_ON_RESET=0, dm_ready goes high on the first posedge after reset deasserts.
- State CLR:
  - Each cycle: mem[clr_cnt] <= 0, clr_cnt <= clr_cnt+1.
  - At clr_cnt==DEPTH-1: write the last word, then state=RDY. CLR lasts exactly DEPTH cycles after reset release.
  - dm_wen is ignored; dm_rdata is held at 0; dm_ready=0.
- State RDY:
  - Every posedge: dm_rdata <= mem[idx], read-first (returns the contents before any same-cycle write).
  - For each i with dm_wen[i]=1: mem[idx][8i+7:8i] <= dm_wdata[8i+7:8i]. Lanes with dm_wen[i]=0 are unchanged.
  - Read latency is 1 cycle. Reads occur every cycle; there is no enable.
  - Write-then-read to the same word in consecutive cycles returns the new data.
- Address wrap: without range checking, addresses alias modulo DEPTH words. Upper bits above ADDR_WIDTH+1 are ignored.
- Reset in CLR: clr_cnt restarts at 0 and the full DEPTH-cycle clear repeats.
- Reset in RDY:
  - CLEAR_ON_RESET=1: memory is re-cleared.
  - CLEAR_ON_RESET=0: memory contents are preserved; only dm_rdata is zeroed.
- Misalignment: no alignment checking; MEM already suppresses dm_wen on misaligned stores.
- No other state; FSM encoding is implementation's choice (2 states).

Optional Feature:
DM_RANGE_CHK_EN
- Defined:
  - An access is out of range when (dm_addr - BASE_ADDR) >= DEPTH*4, unsigned 32-bit compare; the word index is taken from (dm_addr - BASE_ADDR).
  - Out-of-range in RDY: all writes suppressed; dm_rdata <= 0; dm_err <= 1 for that cycle's response (same timing as dm_rdata).
  - In-range: dm_err <= 0.
  - In CLR: dm_err = 0.
- Not defined:
  - No subtractor or comparator; index taken directly from dm_addr, wrapping as above.
  - dm_err tied to 0.

Test Plan:
1. ADDR_WIDTH=4, CLEAR_ON_RESET=1: pre-fill memory with nonzero data, pulse reset 1 cycle -> dm_ready=0 for 16 cycles, =1 on cycle 17; reading 0x0..0x3C then returns 0x00000000.
2. RDY: addr 0x8, wen 4'b1111, wdata 0xDEADBEEF; next cycle addr 0x8, wen 0 -> dm_rdata=0xDEADBEEF one cycle later.
3. Byte and half writes after test 2:
   - addr 0xA, wen 4'b0100, wdata 0x00AA0000 -> readback 0xDEAABEEF.
   - Then wen 4'b0011, wdata 0x00001234 -> readback 0xDEAA1234.
4. Read-first: same cycle addr 0x8, wen 4'b1111, wdata 0x11111111 -> dm_rdata returns 0xDEAA1234; next read returns 0x11111111.
5. Clear restart and persistence:
   - Reset asserted when clr_cnt=5 -> clear restarts; dm_ready rises 16 cycles after final reset release.
   - CLEAR_ON_RESET=0: value written at 0x8 survives a reset pulse.
6. Wrap and range check:
   - Without DM_RANGE_CHK_EN: write 0x55AA55AA at 0x48 -> read 0x08 returns 0x55AA55AA.
   - With it, BASE_ADDR=0x1000: write at 0x1040 -> memory unchanged, dm_rdata=0, dm_err=1 for one cycle; access at 0x1008 -> dm_err=0.
